// File: rtl/unison_capture_pkg.sv
// Shared constants for the unison readout capture block: register map, bit positions and
// sample packing geometry.
package unison_capture_pkg;

  typedef enum logic [1:0] {
    RegData   = 2'd0,
    RegStatus = 2'd1,
    RegCtrl   = 2'd2,
    RegRsvd   = 2'd3
  } reg_sel_e;

  localparam int unsigned StatusEmptyBit = 0;
  localparam int unsigned StatusFullBit  = 1;
  localparam int unsigned StatusOvfBit   = 2;
  localparam int unsigned StatusLevelLsb = 8;

  localparam int unsigned CtrlEnBit  = 0;
  localparam int unsigned CtrlClrBit = 1;
  localparam int unsigned CtrlThrLsb = 8;

  localparam int unsigned SAMPLES_PER_WORD = 8;
  localparam int unsigned SAMPLE_W         = 4;
  localparam int unsigned WORD_W           = SAMPLES_PER_WORD * SAMPLE_W;

endpackage

// File: rtl/unison_readout_capture_if.sv
// Wishbone classic slave bundle for the readout capture block.
interface unison_readout_capture_if;
  logic        wbs_stb_i;
  logic        wbs_cyc_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  modport slave (
    input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o
  );

  modport master (
    output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o
  );
endinterface

// File: rtl/unison_capture_fifo.sv
// Synchronous word FIFO with extra-MSB pointers; push while full is accepted only alongside a pop.
module unison_capture_fifo #(
  parameter int unsigned Depth = 16,
  parameter int unsigned Width = 32
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     clear_i,
  input  logic                     push_i,
  input  logic [Width-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [Width-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(Depth):0]   level_o
);

  localparam int unsigned AddrW = $clog2(Depth);

  logic [AddrW:0]   wptr_q, wptr_d;
  logic [AddrW:0]   rptr_q, rptr_d;
  logic [Width-1:0] mem_q [Depth];
  logic             do_push, do_pop;

  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[AddrW] != rptr_q[AddrW]) &&
                   (wptr_q[AddrW-1:0] == rptr_q[AddrW-1:0]);
  assign level_o = wptr_q - rptr_q;
  assign rdata_o = mem_q[rptr_q[AddrW-1:0]];

  assign do_push = push_i && (!full_o || pop_i) && !clear_i;
  assign do_pop  = pop_i && !empty_o && !clear_i;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (clear_i) begin
      wptr_d = '0;
      rptr_d = '0;
    end else begin
      if (do_push) wptr_d = wptr_q + 1'b1;
      if (do_pop)  rptr_d = rptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // Storage needs no reset: empty_o gates every read of stale contents.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q[AddrW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/unison_readout_capture.sv
// Captures 4-bit I/Q readout samples on clk_master rising edges, packs 8 per word into a FIFO
// drained over Wishbone. Optional FIFO-level interrupt under UNISON_CAPTURE_IRQ_EN.
module unison_readout_capture
  import unison_capture_pkg::*;
#(
  parameter int unsigned DEPTH       = 16,
  parameter logic [31:0] BASE_ADR    = 32'h3000_0000,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                     wb_clk_i,
  input  logic                     rstb,
  unison_readout_capture_if.slave  wb,
  input  logic                     clk_master,
  input  logic [1:0]               read_out_I,
  input  logic [1:0]               read_out_Q,
  output logic                     capture_irq
);

  localparam int unsigned LvlW  = $clog2(DEPTH) + 1;
  localparam int unsigned CntW  = $clog2(SAMPLES_PER_WORD);
  localparam int unsigned PartW = WORD_W - SAMPLE_W;

  // Strobe and data share one synchronizer so they stay aligned.
  logic [4:0] sync_q [SYNC_STAGES];
  logic [4:0] sync_d [SYNC_STAGES];
  logic       clk_prev_q, clk_prev_d;
  logic       clk_s, edge_det;
  logic [SAMPLE_W-1:0] sample;

  always_comb begin
    sync_d[0] = {clk_master, read_out_I, read_out_Q};
    for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_d[i] = sync_q[i-1];
  end

  assign clk_s      = sync_q[SYNC_STAGES-1][4];
  assign sample     = sync_q[SYNC_STAGES-1][3:0];
  assign clk_prev_d = clk_s;
  assign edge_det   = clk_s && !clk_prev_q;

  logic              ack_q, ack_d;
  logic [31:0]       dat_q, dat_d;
  logic              pop_pend_q, pop_pend_d;
  logic              wr_pend_q, wr_pend_d;
  reg_sel_e          wr_reg_q, wr_reg_d;
  logic [15:0]       wdat_q, wdat_d;
  logic              en_q, en_d;
  logic              ovf_q, ovf_d;
  logic [PartW-1:0]  word_q, word_d;
  logic [CntW-1:0]   cnt_q, cnt_d;

  logic              req, hit;
  reg_sel_e          reg_sel;
  logic [31:0]       rd_data;
  logic [7:0]        thr;
  logic              clear, push, pop;
  logic [WORD_W-1:0] push_word;
  logic [WORD_W-1:0] fifo_rdata;
  logic              fifo_full, fifo_empty;
  logic [LvlW-1:0]   fifo_level;

  assign req     = wb.wbs_stb_i && wb.wbs_cyc_i && !ack_q;
  assign hit     = (wb.wbs_adr_i[31:8] == BASE_ADR[31:8]);
  assign reg_sel = reg_sel_e'(wb.wbs_adr_i[3:2]);

  always_comb begin
    rd_data = '0;
    if (hit) begin
      case (reg_sel)
        RegData:   rd_data = fifo_empty ? '0 : fifo_rdata;
        RegStatus: begin
          rd_data[StatusEmptyBit]        = fifo_empty;
          rd_data[StatusFullBit]         = fifo_full;
          rd_data[StatusOvfBit]          = ovf_q;
          rd_data[StatusLevelLsb +: 8]   = 8'(fifo_level);
        end
        RegCtrl: begin
          rd_data[CtrlEnBit]      = en_q;
          rd_data[CtrlThrLsb +: 8] = thr;
        end
        default: rd_data = '0;
      endcase
    end
  end

  // The request is latched at the strobe edge; pop and write side effects land in the ack cycle.
  always_comb begin
    ack_d      = req;
    dat_d      = (req && !wb.wbs_we_i) ? rd_data : '0;
    pop_pend_d = req && !wb.wbs_we_i && hit && (reg_sel == RegData) && !fifo_empty;
    wr_pend_d  = req && wb.wbs_we_i && hit && wb.wbs_sel_i[0];
    wr_reg_d   = reg_sel;
    wdat_d     = wb.wbs_dat_i[15:0];
  end

  assign clear = wr_pend_q && (wr_reg_q == RegCtrl) && wdat_q[CtrlClrBit];
  assign pop   = pop_pend_q;

  always_comb begin
    en_d = en_q;
    if (wr_pend_q && (wr_reg_q == RegCtrl)) en_d = wdat_q[CtrlEnBit];
  end

  always_comb begin
    word_d    = word_q;
    cnt_d     = cnt_q;
    push      = 1'b0;
    push_word = {word_q, sample};
    if (clear) begin
      word_d = '0;
      cnt_d  = '0;
    end else if (edge_det && en_q) begin
      word_d = push_word[PartW-1:0];
      cnt_d  = cnt_q + 1'b1;
      push   = (cnt_q == CntW'(SAMPLES_PER_WORD - 1));
    end
  end

  always_comb begin
    ovf_d = ovf_q;
    if (clear) begin
      ovf_d = 1'b0;
    end else if (push && fifo_full && !pop) begin
      ovf_d = 1'b1;
    end else if (wr_pend_q && (wr_reg_q == RegStatus) && wdat_q[StatusOvfBit]) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (!rstb) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      clk_prev_q <= 1'b0;
      ack_q      <= 1'b0;
      dat_q      <= '0;
      pop_pend_q <= 1'b0;
      wr_pend_q  <= 1'b0;
      wr_reg_q   <= RegData;
      wdat_q     <= '0;
      en_q       <= 1'b0;
      ovf_q      <= 1'b0;
      word_q     <= '0;
      cnt_q      <= '0;
    end else begin
      sync_q     <= sync_d;
      clk_prev_q <= clk_prev_d;
      ack_q      <= ack_d;
      dat_q      <= dat_d;
      pop_pend_q <= pop_pend_d;
      wr_pend_q  <= wr_pend_d;
      wr_reg_q   <= wr_reg_d;
      wdat_q     <= wdat_d;
      en_q       <= en_d;
      ovf_q      <= ovf_d;
      word_q     <= word_d;
      cnt_q      <= cnt_d;
    end
  end

  assign wb.wbs_ack_o = ack_q;
  assign wb.wbs_dat_o = dat_q;

  unison_capture_fifo #(
    .Depth (DEPTH),
    .Width (WORD_W)
  ) u_fifo (
    .clk_i   (wb_clk_i),
    .rst_ni  (rstb),
    .clear_i (clear),
    .push_i  (push),
    .wdata_i (push_word),
    .pop_i   (pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );

`ifdef UNISON_CAPTURE_IRQ_EN
  logic [7:0] thr_q, thr_d;
  logic       irq_q, irq_d;

  always_comb begin
    thr_d = thr_q;
    if (wr_pend_q && (wr_reg_q == RegCtrl)) thr_d = wdat_q[CtrlThrLsb +: 8];
    irq_d = (thr_q != '0) && (32'(fifo_level) >= 32'(thr_q));
  end

  always_ff @(posedge wb_clk_i) begin
    if (!rstb) begin
      thr_q <= '0;
      irq_q <= 1'b0;
    end else begin
      thr_q <= thr_d;
      irq_q <= irq_d;
    end
  end

  assign thr         = thr_q;
  assign capture_irq = irq_q;

  logic unused_bits;
  assign unused_bits = ^{wb.wbs_sel_i[3:1], wb.wbs_adr_i[7:4], wb.wbs_adr_i[1:0],
                         wb.wbs_dat_i[31:16], wdat_q[7:3]};
`else
  assign thr         = '0;
  assign capture_irq = 1'b0;

  logic unused_bits;
  assign unused_bits = ^{wb.wbs_sel_i[3:1], wb.wbs_adr_i[7:4], wb.wbs_adr_i[1:0],
                         wb.wbs_dat_i[31:16], wdat_q[15:3]};
`endif

endmodule

// File: tb/tb_unison_readout_capture.sv
// Self-checking bench: randomized readout samples against a queue-based model of the capture path.
module tb_unison_readout_capture;

  localparam int unsigned Depth = 16;
  localparam logic [31:0] Base  = 32'h3000_0000;
  localparam logic [31:0] AdrData   = Base + 32'h0;
  localparam logic [31:0] AdrStatus = Base + 32'h4;
  localparam logic [31:0] AdrCtrl   = Base + 32'h8;
  localparam logic [31:0] AdrRsvd   = Base + 32'hC;

  logic       wb_clk_i = 1'b0;
  logic       rstb = 1'b0;
  logic       clk_master = 1'b0;
  logic [1:0] read_out_I = '0;
  logic [1:0] read_out_Q = '0;
  logic       capture_irq;

  unison_readout_capture_if wb_if ();

  unison_readout_capture #(
    .DEPTH       (Depth),
    .BASE_ADR    (Base),
    .SYNC_STAGES (2)
  ) dut (
    .wb_clk_i    (wb_clk_i),
    .rstb        (rstb),
    .wb          (wb_if),
    .clk_master  (clk_master),
    .read_out_I  (read_out_I),
    .read_out_Q  (read_out_Q),
    .capture_irq (capture_irq)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  int checks = 0;
  int errors = 0;

  // Reference model: nibbles collected so far, stored words, sticky overflow, enable.
  logic [3:0]  part_m[$];
  logic [31:0] fifo_m[$];
  bit          ovf_m = 1'b0;
  bit          en_m  = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge wb_clk_i);
    #1;
  endtask

  task automatic model_sample(input logic [3:0] s);
    logic [31:0] w;
    if (!en_m) return;
    part_m.push_back(s);
    if (part_m.size() == 8) begin
      w = 0;
      for (int k = 0; k < 8; k++) w = w + (32'(part_m[k]) << (28 - 4 * k));
      part_m.delete();
      if (fifo_m.size() == Depth) ovf_m = 1'b1;
      else fifo_m.push_back(w);
    end
  endtask

  function automatic logic [31:0] model_pop();
    if (fifo_m.size() == 0) return 32'h0;
    return fifo_m.pop_front();
  endfunction

  function automatic logic [31:0] exp_status();
    logic [31:0] s = '0;
    s[0]    = (fifo_m.size() == 0);
    s[1]    = (fifo_m.size() == Depth);
    s[2]    = ovf_m;
    s[15:8] = 8'(fifo_m.size());
    return s;
  endfunction

  task automatic model_clear();
    part_m.delete();
    fifo_m.delete();
    ovf_m = 1'b0;
  endtask

  task automatic wb_xfer(input logic we, input logic [31:0] adr, input logic [31:0] wdat,
                         input logic [3:0] sel, output logic [31:0] rdat);
    int n = 0;
    wb_if.wbs_cyc_i = 1'b1;
    wb_if.wbs_stb_i = 1'b1;
    wb_if.wbs_we_i  = we;
    wb_if.wbs_adr_i = adr;
    wb_if.wbs_dat_i = wdat;
    wb_if.wbs_sel_i = sel;
    do begin
      step();
      n++;
    end while (!wb_if.wbs_ack_o && n < 8);
    check_eq("wb_ack", {31'b0, wb_if.wbs_ack_o}, 32'h1);
    rdat = wb_if.wbs_dat_o;
    wb_if.wbs_cyc_i = 1'b0;
    wb_if.wbs_stb_i = 1'b0;
    wb_if.wbs_we_i  = 1'b0;
  endtask

  task automatic wb_read(input logic [31:0] adr, output logic [31:0] d);
    wb_xfer(1'b0, adr, 32'h0, 4'hF, d);
  endtask

  task automatic wb_write(input logic [31:0] adr, input logic [31:0] d, input logic [3:0] sel);
    logic [31:0] unused_d;
    wb_xfer(1'b1, adr, d, sel, unused_d);
  endtask

  task automatic drive_sample(input logic [3:0] s);
    read_out_I = s[3:2];
    read_out_Q = s[1:0];
    repeat (3) step();
    clk_master = 1'b1;
    repeat (4) step();
    clk_master = 1'b0;
    repeat (3) step();
    model_sample(s);
  endtask

  task automatic drive_word_random();
    for (int k = 0; k < 8; k++) drive_sample(4'($urandom));
  endtask

  task automatic drain_and_check(input string tag);
    logic [31:0] d;
    int n = fifo_m.size();
    for (int k = 0; k < n; k++) begin
      wb_read(AdrData, d);
      check_eq(tag, d, model_pop());
    end
  endtask

  initial begin
    logic [31:0] d;
    logic [31:0] exp_a;
    logic [3:0]  s;

    wb_if.wbs_cyc_i = 1'b0;
    wb_if.wbs_stb_i = 1'b0;
    wb_if.wbs_we_i  = 1'b0;
    wb_if.wbs_sel_i = 4'h0;
    wb_if.wbs_adr_i = '0;
    wb_if.wbs_dat_i = '0;

    repeat (3) step();
    check_eq("reset_ack", {31'b0, wb_if.wbs_ack_o}, 32'h0);
    check_eq("reset_dat", wb_if.wbs_dat_o, 32'h0);
    check_eq("reset_irq", {31'b0, capture_irq}, 32'h0);
    rstb = 1'b1;
    step();

    wb_read(AdrStatus, d);  check_eq("reset_status", d, 32'h0000_0001);
    wb_read(AdrCtrl, d);    check_eq("reset_ctrl", d, 32'h0);
    wb_read(AdrRsvd, d);    check_eq("rsvd_read", d, 32'h0);
    wb_read(32'h4000_0004, d); check_eq("window_miss_read", d, 32'h0);

    // Constant pattern I=10, Q=01
    wb_write(AdrCtrl, 32'h1, 4'hF);
    en_m = 1'b1;
    wb_read(AdrCtrl, d);    check_eq("ctrl_enable", d, 32'h1);
    for (int k = 0; k < 8; k++) drive_sample(4'b1001);
    wb_read(AdrData, d);    check_eq("pattern_9999", d, 32'h9999_9999);
    void'(model_pop());
    wb_read(AdrStatus, d);  check_eq("pattern_status", d, 32'h0000_0001);

    for (int k = 0; k < 8; k++) drive_sample(4'(k));
    wb_read(AdrData, d);    check_eq("pack_order", d, 32'h0123_4567);
    void'(model_pop());
    wb_read(AdrData, d);    check_eq("pop_empty", d, 32'h0);
    wb_read(AdrStatus, d);  check_eq("pop_empty_status", d, 32'h0000_0001);

    // An out-of-window DATA read must not pop
    drive_word_random();
    wb_read(Base + 32'h100, d); check_eq("miss_no_pop", d, 32'h0);
    wb_read(AdrStatus, d);  check_eq("miss_status", d, exp_status());
    drain_and_check("miss_data");

    // Overflow: 17 words, 16 survive
    for (int w = 0; w < 17; w++) drive_word_random();
    wb_read(AdrStatus, d);  check_eq("ovf_status", d, exp_status());
    check_eq("ovf_status_lit", d, 32'h0000_1006);
`ifndef UNISON_CAPTURE_IRQ_EN
    check_eq("irq_tied_off", {31'b0, capture_irq}, 32'h0);
`endif
    drain_and_check("ovf_data");
    wb_read(AdrStatus, d);  check_eq("ovf_sticky", d, 32'h0000_0005);

    // Clear flushes the partial word and overflow
    for (int k = 0; k < 5; k++) drive_sample(4'($urandom));
    wb_write(AdrCtrl, 32'h3, 4'hF);
    model_clear();
    wb_read(AdrStatus, d);  check_eq("clear_status", d, exp_status());
    wb_read(AdrCtrl, d);    check_eq("clear_self_clears", d, 32'h1);
    for (int k = 0; k < 8; k++) drive_sample(4'(10 - k));
    wb_read(AdrData, d);    check_eq("clear_no_stale", d, 32'hA987_6543);
    void'(model_pop());

    // Overflow again, then write-1-to-clear with and without sel[0]
    for (int w = 0; w < 17; w++) drive_word_random();
    wb_write(AdrStatus, 32'h4, 4'hE);
    wb_read(AdrStatus, d);  check_eq("w1c_sel_gated", d, exp_status());
    wb_write(AdrStatus, 32'h4, 4'h1);
    ovf_m = 1'b0;
    wb_read(AdrStatus, d);  check_eq("w1c_status", d, exp_status());
    drain_and_check("w1c_data");

    // Random samples with enable toggling
    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(0, 4) == 0) begin
        en_m = !en_m;
        wb_write(AdrCtrl, {31'b0, en_m}, 4'hF);
      end
      drive_sample(4'($urandom));
    end
    wb_read(AdrStatus, d);  check_eq("rand_status", d, exp_status());
    drain_and_check("rand_data");
    wb_read(AdrData, d);    check_eq("rand_empty_pop", d, 32'h0);

    // Push lands in the ack cycle of a DATA pop
    wb_write(AdrCtrl, 32'h3, 4'hF);
    en_m = 1'b1;
    model_clear();
    drive_word_random();
    for (int k = 0; k < 7; k++) drive_sample(4'($urandom));
    s = 4'($urandom);
    read_out_I = s[3:2];
    read_out_Q = s[1:0];
    repeat (3) step();
    clk_master = 1'b1;
    step();
    wb_read(AdrData, d);
    exp_a = model_pop();
    check_eq("pushpop_data", d, exp_a);
    repeat (2) step();
    clk_master = 1'b0;
    repeat (3) step();
    model_sample(s);
    wb_read(AdrStatus, d);  check_eq("pushpop_level", d, exp_status());
    check_eq("pushpop_level_lit", d, 32'h0000_0100);
    wb_read(AdrData, d);    check_eq("pushpop_next", d, model_pop());

    // Threshold field and interrupt
    wb_write(AdrCtrl, 32'h0000_0403, 4'hF);
    model_clear();
    wb_read(AdrCtrl, d);
`ifdef UNISON_CAPTURE_IRQ_EN
    check_eq("ctrl_threshold", d, 32'h0000_0401);
    for (int w = 0; w < 3; w++) drive_word_random();
    check_eq("irq_below", {31'b0, capture_irq}, 32'h0);
    for (int k = 0; k < 7; k++) drive_sample(4'($urandom));
    s = 4'($urandom);
    read_out_I = s[3:2];
    read_out_Q = s[1:0];
    repeat (3) step();
    clk_master = 1'b1;
    repeat (3) step();
    check_eq("irq_push_cycle", {31'b0, capture_irq}, 32'h0);
    step();
    check_eq("irq_rise", {31'b0, capture_irq}, 32'h1);
    clk_master = 1'b0;
    repeat (3) step();
    model_sample(s);
    wb_read(AdrData, d);    check_eq("irq_pop_data", d, model_pop());
    check_eq("irq_ack_cycle", {31'b0, capture_irq}, 32'h1);
    step();
    check_eq("irq_pop_commit", {31'b0, capture_irq}, 32'h1);
    step();
    check_eq("irq_fall", {31'b0, capture_irq}, 32'h0);
`else
    check_eq("ctrl_threshold", d, 32'h0000_0001);
    for (int w = 0; w < 4; w++) drive_word_random();
    check_eq("irq_disabled", {31'b0, capture_irq}, 32'h0);
`endif
    wb_read(AdrStatus, d);  check_eq("irq_status", d, exp_status());

    // Reset while a read is being acked
    wb_if.wbs_cyc_i = 1'b1;
    wb_if.wbs_stb_i = 1'b1;
    wb_if.wbs_we_i  = 1'b0;
    wb_if.wbs_adr_i = AdrStatus;
    step();
    rstb = 1'b0;
    step();
    check_eq("rst_mid_ack", {31'b0, wb_if.wbs_ack_o}, 32'h0);
    check_eq("rst_mid_dat", wb_if.wbs_dat_o, 32'h0);
    wb_if.wbs_cyc_i = 1'b0;
    wb_if.wbs_stb_i = 1'b0;
    rstb = 1'b1;
    step();
    en_m = 1'b0;
    model_clear();
    wb_read(AdrStatus, d);  check_eq("rst_mid_status", d, exp_status());

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
